// File: rtl/fd_pkg.sv
// Shared defaults for the fetch-to-decode instruction queue.
package fd_pkg;

  localparam int                INSTR_W_DEF      = 32;
  localparam int                PC_W_DEF         = 32;
  localparam logic [31:0]       BUBBLE_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/fd_ring_buf.sv
// Circular buffer with explicit occupancy count; storage itself is never reset.
module fd_ring_buf #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !clear && !rst;
  assign do_pop  = pop && !empty && !clear && !rst;
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fd_inst_queue.sv
// Fetch/decode boundary: instruction queue with empty-queue bypass into a decode register.
module fd_inst_queue
  import fd_pkg::*;
#(
  parameter int                 DEPTH        = 4,
  parameter int                 INSTR_W      = INSTR_W_DEF,
  parameter int                 PC_W         = PC_W_DEF,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(BUBBLE_INSTR_DEF)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       F_Valid,
  input  logic [INSTR_W-1:0]         F_Instruction,
  input  logic [PC_W-1:0]            F_PC,
  output logic                       F_Ready,
  input  logic                       D_Stall,
  output logic [INSTR_W-1:0]         D_Instruction,
  output logic [PC_W-1:0]            D_PC,
  output logic                       D_Valid,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int W = INSTR_W + PC_W;

  logic         full;
  logic         empty;
  logic         push_ok;
  logic         advance;
  logic         bypass;
  logic         q_push;
  logic         q_pop;
  logic [W-1:0] head_data;

  assign F_Ready = !full;
  assign push_ok = F_Valid && !full;
  assign advance = !D_Stall;
  assign bypass  = advance && empty && push_ok;
  assign q_push  = push_ok && !bypass && !Flush;
  assign q_pop   = advance && !empty && !Flush;

  fd_ring_buf #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ring (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (Flush),
    .push    (q_push),
    .pop     (q_pop),
    .wr_data ({F_PC, F_Instruction}),
    .rd_data (head_data),
    .count   (Count),
    .empty   (empty),
    .full    (full)
  );

  // Decode register: queue head beats bypass, bypass beats bubble; D_PC holds on bubbles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      D_Instruction <= '0;
      D_PC          <= '0;
      D_Valid       <= 1'b0;
    end else if (Flush) begin
      D_Instruction <= BUBBLE_INSTR;
      D_Valid       <= 1'b0;
    end else if (advance) begin
      if (!empty) begin
        D_Instruction <= head_data[INSTR_W-1:0];
        D_PC          <= head_data[W-1:INSTR_W];
        D_Valid       <= 1'b1;
      end else if (push_ok) begin
        D_Instruction <= F_Instruction;
        D_PC          <= F_PC;
        D_Valid       <= 1'b1;
      end else begin
        D_Instruction <= BUBBLE_INSTR;
        D_Valid       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fd_inst_queue.md
# fd_inst_queue

Parametrised fetch-to-decode boundary: replaces the single F/D pipeline register with a DEPTH-entry circular instruction queue feeding a decode-stage output register. Fetch can run ahead of a stalled decode stage. When the queue is empty, instructions bypass straight to decode with the same one-cycle latency as a plain pipeline register. A flush discards everything in flight. A bubble (NOP, D_Valid low) is presented whenever decode advances with nothing to issue.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- INSTR_W, 32: instruction width.
- PC_W, 32: PC width.
- BUBBLE_INSTR, 0: instruction word presented during a bubble.

Ports:
- Clk  in  1: single clock, rising-edge.
- Reset  in  1: synchronous, active-high reset.
- Flush  in  1: discard queue contents and decode register.
- F_Valid  in  1: fetch presents an instruction this cycle.
- F_Instruction  in  INSTR_W: fetched instruction.
- F_PC  in  PC_W: PC of the fetched instruction.
- F_Ready  out  1: queue can accept; equals (Count < DEPTH); depends only on registered state.
- D_Stall  in  1: decode holds its current instruction.
- D_Instruction  out  INSTR_W: instruction in decode.
- D_PC  out  PC_W: PC in decode.
- D_Valid  out  1: D_Instruction is a real instruction, not a bubble.
- Count  out  $clog2(DEPTH+1): number of occupied queue entries; excludes the decode register.

## Operation
- Push: F_Valid && F_Ready. The entry is written at the tail, unless the bypass condition holds.
- Advance: !D_Stall. The decode register loads from one of three sources, in priority order:
  - Queue non-empty: load the head entry and pop it; D_Valid <= 1.
  - Queue empty and push this cycle: bypass, loading F_Instruction/F_PC directly; the queue is not written and Count is unchanged; D_Valid <= 1.
  - Otherwise: bubble; D_Instruction <= BUBBLE_INSTR, D_PC holds its previous value, D_Valid <= 0.
- Simultaneous pop and push with a non-empty queue: head goes to decode, F goes to tail, Count unchanged.
- Stall (D_Stall=1): decode register holds all three outputs. A push still writes the tail if F_Ready.
- Full (Count = DEPTH): F_Ready=0. A push is not accepted even if a pop occurs in the same cycle.
- Pointers: head and tail are $clog2(DEPTH)-bit and wrap modulo DEPTH. Count is tracked explicitly, giving the empty/full distinction.
- Priority: Reset > Flush > normal operation.
- Flush: head = tail = 0, Count = 0, D_Instruction <= BUBBLE_INSTR, D_Valid <= 0, D_PC holds. Any push presented that cycle is dropped. D_Stall is ignored.
- Reset: D_Instruction = 0, D_PC = 0, D_Valid = 0, Count = 0, pointers 0, F_Ready = 1. Reset mid-operation drops all entries. Queue storage contents are don't-care.

## Timing
- F→D latency when the queue is empty and decode is not stalled: 1 cycle (bypass).
- Latency otherwise: 1 + number of older entries ahead of the instruction, plus stall cycles.
- All outputs are registered or derived from registered state only; there is no combinational path from F_Valid or D_Stall to any output.
- Count and F_Ready update on the edge after the push or pop.
- Flush takes effect on the edge where it is sampled. The next cycle shows an empty queue and a bubble in decode.
- Instructions leave strictly in push order; none is duplicated or lost except by Flush or Reset.

## Structure
- Shared package fd_pkg holds INSTR_W/PC_W defaults and the BUBBLE_INSTR default (32'h0). The pointer and count widths are derived locally from DEPTH.
- Sub-module fd_ring_buf contains storage, head/tail/count, and push/pop with full/empty flags. The top level adds the bypass mux, the decode register, and flush/stall priority.

## Test plan
- Reset, then push PC 0x3000 / instruction 0x24010001 with D_Stall=0 → next cycle D_PC=0x3000, D_Valid=1, Count=0 (bypass).
- Hold D_Stall=1 and push 5 instructions with DEPTH=4 → Count reaches 4, F_Ready=0, 5th push rejected, decode unchanged. Release the stall → entries appear in order, one per cycle; a bubble with D_PC held follows the last entry.
- Queue at Count=2 with simultaneous push and pop → Count stays 2; the head reaches decode.
- Flush at Count=3 with F_Valid=1 → next cycle Count=0, D_Valid=0, D_Instruction=0, D_PC unchanged; the flushed-cycle fetch never reaches decode.
- Reset asserted with Count=3 and D_Stall=1 → all outputs at reset values the next cycle.
- Wrap-around: 10 continuous push/pop pairs with a 1-cycle stall every 3 cycles → PC sequence at decode matches push order with no loss past pointer wrap.
